agc_scale_multi: RTL

- Multi-channel, fully parametrised successor to the single-lane AGC DSP scaler.
- Each of CHANNELS lanes computes out = sat(((dat + offset) * scale) >> DESIRED_LSB).
- Per-lane coefficients are double-buffered: loaded into staging registers, then made active globally by one apply strobe.
- A windowed statistics engine counts per-lane high/low saturation events so firmware can close the AGC loop. Sits between the ADC sample stream and the trigger/beamformer.

---
 rtl/agc_scale_multi.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/agc_scale_multi.sv
// agc_scale_multi: multi-lane AGC scaler, out = sat(((dat + offset) * scale) >> DESIRED_LSB),
// with double-buffered per-lane coefficients and windowed saturation statistics.
// Build option: define AGC_ROUND_EN to round half up before saturation;
// the default build truncates toward minus infinity. Latency is 4 either way.
//
// Statistics FSM
//   state   | meaning
//   ST_IDLE | no window started since reset
//   ST_RUN  | window open, saturation events counted on each valid output
//   ST_DONE | window complete, counts final and held
module agc_scale_multi #(
    parameter int CHANNELS    = 8,
    parameter int DAT_BITS    = 12,
    parameter int Q_DAT       = 0,
    parameter int OFFSET_BITS = 16,
    parameter int Q_OFFSET    = 8,
    parameter int SCALE_BITS  = 17,
    parameter int Q_SCALE     = 12,
    parameter int SCALE_IN    = 5,
    parameter int NFRAC_OUT   = 2,
    parameter int NBITS       = 5,
    parameter int WINDOW_LEN  = 65536,
    parameter int CNT_BITS    = 17,
    parameter     CLKTYPE     = "NONE"
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [CHANNELS*DAT_BITS-1:0]          dat_i,
    input  logic                                  dat_valid_i,
    input  logic [((CHANNELS>1)?$clog2(CHANNELS):1)-1:0] ch_sel_i,
    input  logic [SCALE_BITS-1:0]                 scale_i,
    input  logic [OFFSET_BITS-1:0]                offset_i,
    input  logic                                  ce_scale_i,
    input  logic                                  ce_offset_i,
    input  logic                                  apply_i,
    input  logic                                  stat_start_i,
    output logic [CHANNELS*NBITS-1:0]             out_o,
    output logic [CHANNELS*(NBITS-1)-1:0]         abs_o,
    output logic [CHANNELS-1:0]                   gt_o,
    output logic [CHANNELS-1:0]                   lt_o,
    output logic                                  out_valid_o,
    output logic [CHANNELS*CNT_BITS-1:0]          gt_count_o,
    output logic [CHANNELS*CNT_BITS-1:0]          lt_count_o,
    output logic                                  stat_busy_o,
    output logic                                  stat_valid_o
);
    localparam int Q_SUM       = (Q_DAT > Q_OFFSET) ? Q_DAT : Q_OFFSET;
    localparam int DESIRED_LSB = Q_SUM + Q_SCALE + SCALE_IN - NFRAC_OUT;
    localparam int DAT_W       = DAT_BITS + Q_SUM - Q_DAT;
    localparam int OFF_W       = OFFSET_BITS + Q_SUM - Q_OFFSET;
    localparam int SUM_W       = ((DAT_W > OFF_W) ? DAT_W : OFF_W) + 1;
    localparam int P_W         = SUM_W + SCALE_BITS + 1;
    // one spare bit so the rounding increment can never wrap
    localparam int PR_W        = P_W + 1;
    localparam int WIN_W       = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
`ifdef AGC_ROUND_EN
    localparam logic signed [PR_W-1:0] RND = {{(PR_W-1){1'b0}}, 1'b1} <<< (DESIRED_LSB - 1);
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} stat_state_t;

    logic [1:0] rst_sync;
    logic       rst_int_n;

    (* clktype = CLKTYPE *) logic        [SCALE_BITS-1:0]  stg_scale  [CHANNELS];
    (* clktype = CLKTYPE *) logic signed [OFFSET_BITS-1:0] stg_offset [CHANNELS];
    (* clktype = CLKTYPE *) logic        [SCALE_BITS-1:0]  act_scale  [CHANNELS];
    (* clktype = CLKTYPE *) logic signed [OFFSET_BITS-1:0] act_offset [CHANNELS];

    logic signed [DAT_BITS-1:0]    dat_s1   [CHANNELS];
    logic signed [OFFSET_BITS-1:0] off_s1   [CHANNELS];
    logic        [SCALE_BITS-1:0]  scale_s1 [CHANNELS];
    logic        [SCALE_BITS-1:0]  scale_s2 [CHANNELS];
    logic signed [SUM_W-1:0]       sum_s2   [CHANNELS];
    logic signed [P_W-1:0]         prod_s3  [CHANNELS];
    logic signed [PR_W-1:0]        prod_r   [CHANNELS];
    logic signed [NBITS-1:0]       sat_out  [CHANNELS];
    logic        [CHANNELS-1:0]    sat_gt, sat_lt;
    logic signed [NBITS-1:0]       out_q    [CHANNELS];
    logic        [NBITS-2:0]       abs_q    [CHANNELS];
    logic        [CHANNELS-1:0]    gt_q, lt_q;
    logic        [3:0]             vld_pipe;

    stat_state_t               state, state_nxt;
    logic                      stat_clr, stat_cnt;
    logic [WIN_W-1:0]          win_cnt;
    logic [CNT_BITS-1:0]       gt_cnt [CHANNELS];
    logic [CNT_BITS-1:0]       lt_cnt [CHANNELS];

    // Reset asserts asynchronously and releases on a clock edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rst_sync <= '0;
        else         rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    // Staging writes per lane; apply copies the pre-write staging values to active.
    always_ff @(posedge clk_i or negedge rst_int_n) begin
        if (!rst_int_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                stg_scale[i]  <= '0;
                stg_offset[i] <= '0;
                act_scale[i]  <= '0;
                act_offset[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (apply_i) begin
                    act_scale[i]  <= stg_scale[i];
                    act_offset[i] <= stg_offset[i];
                end
                if (ce_scale_i && int'(ch_sel_i) == i)  stg_scale[i]  <= scale_i;
                if (ce_offset_i && int'(ch_sel_i) == i) stg_offset[i] <= offset_i;
            end
        end
    end

    // S1 capture, S2 aligned pre-add, S3 multiply by zero-extended scale.
    always_ff @(posedge clk_i or negedge rst_int_n) begin
        if (!rst_int_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                dat_s1[i]   <= '0;
                off_s1[i]   <= '0;
                scale_s1[i] <= '0;
                scale_s2[i] <= '0;
                sum_s2[i]   <= '0;
                prod_s3[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                dat_s1[i]   <= dat_i[i*DAT_BITS +: DAT_BITS];
                off_s1[i]   <= act_offset[i];
                scale_s1[i] <= act_scale[i];
                sum_s2[i]   <= (SUM_W'(dat_s1[i]) <<< (Q_SUM - Q_DAT))
                             + (SUM_W'(off_s1[i]) <<< (Q_SUM - Q_OFFSET));
                scale_s2[i] <= scale_s1[i];
                prod_s3[i]  <= P_W'(sum_s2[i]) * $signed(P_W'({1'b0, scale_s2[i]}));
            end
        end
    end

    // Shift product down to the output LSB and clamp when the upper bits disagree.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
`ifdef AGC_ROUND_EN
            prod_r[i] = (PR_W'(prod_s3[i]) + RND) >>> DESIRED_LSB;
`else
            prod_r[i] = PR_W'(prod_s3[i]) >>> DESIRED_LSB;
`endif
            sat_gt[i]  = 1'b0;
            sat_lt[i]  = 1'b0;
            sat_out[i] = prod_r[i][NBITS-1:0];
            if (!((&prod_r[i][PR_W-1:NBITS-1]) || !(|prod_r[i][PR_W-1:NBITS-1]))) begin
                if (!prod_r[i][PR_W-1]) begin
                    sat_out[i] = {1'b0, {(NBITS-1){1'b1}}};
                    sat_gt[i]  = 1'b1;
                end else begin
                    sat_out[i] = {1'b1, {(NBITS-1){1'b0}}};
                    sat_lt[i]  = 1'b1;
                end
            end
        end
    end

    // S4 output register with ones-complement magnitude; valid follows the pipe.
    always_ff @(posedge clk_i or negedge rst_int_n) begin
        if (!rst_int_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                out_q[i] <= '0;
                abs_q[i] <= '0;
            end
            gt_q     <= '0;
            lt_q     <= '0;
            vld_pipe <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                out_q[i] <= sat_out[i];
                abs_q[i] <= sat_out[i][NBITS-1] ? ~sat_out[i][NBITS-2:0] : sat_out[i][NBITS-2:0];
            end
            gt_q     <= sat_gt;
            lt_q     <= sat_lt;
            vld_pipe <= {vld_pipe[2:0], dat_valid_i};
        end
    end

    // Statistics state register.
    always_ff @(posedge clk_i or negedge rst_int_n) begin
        if (!rst_int_n) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    // Statistics next state, status flags and counter controls.
    always_comb begin
        state_nxt    = state;
        stat_busy_o  = 1'b0;
        stat_valid_o = 1'b0;
        stat_clr     = 1'b0;
        stat_cnt     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (stat_start_i) begin
                    state_nxt = ST_RUN;
                    stat_clr  = 1'b1;
                end
            end
            ST_RUN: begin
                stat_busy_o = 1'b1;
                if (vld_pipe[3]) begin
                    stat_cnt = 1'b1;
                    if (win_cnt == '0) state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                stat_valid_o = 1'b1;
                if (stat_start_i) begin
                    state_nxt = ST_RUN;
                    stat_clr  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Window down-counter and per-lane saturating event counters.
    always_ff @(posedge clk_i or negedge rst_int_n) begin
        if (!rst_int_n) begin
            win_cnt <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                gt_cnt[i] <= '0;
                lt_cnt[i] <= '0;
            end
        end else if (stat_clr) begin
            win_cnt <= WIN_W'(WINDOW_LEN - 1);
            for (int i = 0; i < CHANNELS; i++) begin
                gt_cnt[i] <= '0;
                lt_cnt[i] <= '0;
            end
        end else if (stat_cnt) begin
            if (win_cnt != '0) win_cnt <= win_cnt - 1'b1;
            for (int i = 0; i < CHANNELS; i++) begin
                if (gt_q[i] && gt_cnt[i] != '1) gt_cnt[i] <= gt_cnt[i] + 1'b1;
                if (lt_q[i] && lt_cnt[i] != '1) lt_cnt[i] <= lt_cnt[i] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
        assign out_o[g*NBITS +: NBITS]           = out_q[g];
        assign abs_o[g*(NBITS-1) +: NBITS-1]     = abs_q[g];
        assign gt_count_o[g*CNT_BITS +: CNT_BITS] = gt_cnt[g];
        assign lt_count_o[g*CNT_BITS +: CNT_BITS] = lt_cnt[g];
    end
    assign gt_o        = gt_q;
    assign lt_o        = lt_q;
    assign out_valid_o = vld_pipe[3];

endmodule
